// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
// Counter width is derived from the largest of the three timing parameters.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT_RST = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    localparam int unsigned DEF_RESET_CYCLES  = 32;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 27000;
    localparam int unsigned DEF_STABLE_CYCLES = 2700;
    localparam int unsigned DEF_MAX_RETRIES   = 7;

    // Bits needed to hold max(a, b, c) - 1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer; synchronous active-low reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the rPLL reset, qualifies lock and releases the system reset.
// Optional lock-loss counter built only when PLL_SUP_LOSS_CNT_EN is defined.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int unsigned CW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CW-1:0] RST_LAST    = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic          pll_reset_q, sys_rst_n_q, locked_q, fail_q;
    logic          lock_s;
    logic          retry_path;

    sync_2ff u_lock_sync (
        .clk_i   (clkin),
        .rst_n_i (reset_n),
        .d_i     (pll_lock),
        .q_o     (lock_s)
    );

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        retry_path = 1'b0;
        cnt_d      = cnt_q;

        case (state_q)
            ST_ASSERT_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s)                state_d    = ST_STABLE;
                else if (cnt_q == TO_LAST) retry_path = 1'b1;
            end
            ST_STABLE: begin
                // A lock drop beats the terminal count.
                if (!lock_s) begin
                    retry_path = 1'b1;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = 4'd0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_ASSERT_RST;
                    retry_d = 4'd0;
                end
            end
            ST_FAIL: ;
            default: state_d = ST_ASSERT_RST;
        endcase

        if (retry_path) begin
            if (retry_q == RETRY_MAX) begin
                state_d = ST_FAIL;
            end else begin
                retry_d = retry_q + 4'd1;
                state_d = ST_ASSERT_RST;
            end
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_ASSERT_RST || state_q == ST_WAIT_LOCK ||
                     state_q == ST_STABLE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they move with the state register.
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            state_q     <= ST_ASSERT_RST;
            cnt_q       <= '0;
            retry_q     <= 4'd0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == ST_ASSERT_RST) || (state_d == ST_FAIL);
            sys_rst_n_q <= (state_d == ST_RUN);
            locked_q    <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

`ifdef PLL_SUP_LOSS_CNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            loss_q <= 8'd0;
        end else if (state_q == ST_RUN && !lock_s && loss_q != 8'hFF) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = 8'd0;
`endif

    assign pll_reset = pll_reset_q;
    assign sys_rst_n = sys_rst_n_q;
    assign locked    = locked_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus randomized lock chatter
// checked against a phase/elapsed-time model of the supervisor.
module tb_pll_lock_supervisor;

    localparam int R = 4;
    localparam int T = 20;
    localparam int S = 8;
    localparam int M = 2;

    localparam int P_PULSE  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAIL   = 4;

    logic       clkin = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset, sys_rst_n, locked, fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [15:0] obs;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    int m_phase, m_el, m_retries, m_losses;
    bit m_s1, m_s2;

    pll_lock_supervisor #(
        .RESET_CYCLES  (R),
        .LOCK_TIMEOUT  (T),
        .STABLE_CYCLES (S),
        .MAX_RETRIES   (M)
    ) dut (
        .clkin     (clkin),
        .reset_n   (reset_n),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .sys_rst_n (sys_rst_n),
        .locked    (locked),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #5 clkin = ~clkin;

    assign obs = {pll_reset, sys_rst_n, locked, fail, retry_cnt, loss_cnt};

    // Model: a phase plus the number of whole cycles spent in it.
    task automatic model_edge(input bit rn, input bit li);
        bit ls;
        bit retry;
        retry = 1'b0;
        if (!rn) begin
            m_phase = P_PULSE; m_el = 0; m_retries = 0; m_losses = 0;
            m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            ls = m_s2;
            m_s2 = m_s1;
            m_s1 = li;
            case (m_phase)
                P_PULSE: begin
                    m_el++;
                    if (m_el == R) begin m_phase = P_WAIT; m_el = 0; end
                end
                P_WAIT: begin
                    if (ls) begin
                        m_phase = P_STABLE; m_el = 0;
                    end else begin
                        m_el++;
                        if (m_el == T) retry = 1'b1;
                    end
                end
                P_STABLE: begin
                    if (!ls) retry = 1'b1;
                    else begin
                        m_el++;
                        if (m_el == S) begin m_phase = P_RUN; m_el = 0; m_retries = 0; end
                    end
                end
                P_RUN: begin
                    if (!ls) begin
                        m_phase = P_PULSE; m_el = 0; m_retries = 0;
                        if (m_losses < 255) m_losses++;
                    end
                end
                default: ;
            endcase
            if (retry) begin
                if (m_retries == M) m_phase = P_FAIL;
                else begin m_retries++; m_phase = P_PULSE; m_el = 0; end
            end
        end
    endtask

    function automatic logic [15:0] model_out();
        logic [7:0] l;
`ifdef PLL_SUP_LOSS_CNT_EN
        l = 8'(m_losses);
`else
        l = 8'd0;
`endif
        return {(m_phase == P_PULSE) || (m_phase == P_FAIL), m_phase == P_RUN,
                m_phase == P_RUN, m_phase == P_FAIL, 4'(m_retries), l};
    endfunction

    function automatic logic [7:0] exp_loss(input int n);
`ifdef PLL_SUP_LOSS_CNT_EN
        return 8'(n);
`else
        return 8'(n * 0);
`endif
    endfunction

    task automatic step();
        bit li, rn;
        li = pll_lock;
        rn = reset_n;
        @(posedge clkin);
        model_edge(rn, li);
        edge_cnt++;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        edge_cnt = 0;
    endtask

    task automatic wait_sys(input string name, input int bound);
        int n;
        n = 0;
        while (sys_rst_n !== 1'b1 && n < bound) begin step(); n++; end
        n_checks++;
        if (sys_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: sys_rst_n=%b after %0d cycles, required 1", name, sys_rst_n, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pll_lock = 1'b1;
        step(); step();
        n_checks++;
        if (obs !== 16'h8000) begin
            n_fail++;
            $display("FAIL reset_values: got %h required %h", obs, 16'h8000);
        end
    endtask

    task automatic test_clean_lock();
        int n;
        pll_lock = 1'b0;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++;
            if (pll_reset !== (k < 4)) begin
                n_fail++;
                $display("FAIL clean_pulse_edge%0d: pll_reset=%b required %b", k, pll_reset, k < 4);
            end
        end
        step();
        pll_lock = 1'b1;
        n = 0;
        while (sys_rst_n !== 1'b1 && n < 40) begin step(); n++; end
        n_checks++;
        if (n != 3 + S) begin
            n_fail++;
            $display("FAIL clean_release_latency: got %0d edges required %0d", n, 3 + S);
        end
        n_checks++;
        if ({locked, retry_cnt} !== 5'b1_0000) begin
            n_fail++;
            $display("FAIL clean_run_outputs: locked=%b retry=%0d required 1/0", locked, retry_cnt);
        end
    endtask

    task automatic test_chatter();
        int n, bad;
        pll_lock = 1'b0;
        do_reset();
        repeat (5) step();
        pll_lock = 1'b1;
        repeat (7) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        n = 0; bad = 0;
        while (pll_reset !== 1'b1 && n < 20) begin
            if (sys_rst_n !== 1'b0) bad++;
            step(); n++;
        end
        n_checks++;
        if (retry_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL chatter_retry: retry_cnt=%0d required 1", retry_cnt);
        end
        n = 0;
        while (pll_reset === 1'b1 && n < 20) begin
            if (sys_rst_n !== 1'b0) bad++;
            step(); n++;
        end
        n_checks++;
        if (n != R) begin
            n_fail++;
            $display("FAIL chatter_pulse_width: got %0d required %0d", n, R);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL chatter_sys_rst: %0d cycles with sys_rst_n=1 required 0", bad);
        end
        wait_sys("chatter_relock", 40);
    endtask

    task automatic test_no_lock();
        int pulses, first_fail, bad;
        bit prev;
        pll_lock = 1'b0;
        do_reset();
        pulses = 1; first_fail = 0; bad = 0; prev = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (fail === 1'b1 && first_fail == 0) first_fail = edge_cnt;
            if (pll_reset === 1'b1 && !prev && fail !== 1'b1) begin
                n_checks++;
                if (retry_cnt !== 4'(pulses)) begin
                    n_fail++;
                    $display("FAIL nolock_retry_at_pulse%0d: got %0d required %0d", pulses, retry_cnt, pulses);
                end
                pulses++;
            end
            if (first_fail != 0 && {pll_reset, sys_rst_n, fail} !== 3'b101) bad++;
            prev = pll_reset;
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL nolock_pulses: got %0d required 3", pulses);
        end
        n_checks++;
        if (first_fail != 3 * (R + T)) begin
            n_fail++;
            $display("FAIL nolock_fail_edge: got %0d required %0d", first_fail, 3 * (R + T));
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL nolock_sticky: %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_loss_in_run();
        pll_lock = 1'b1;
        do_reset();
        wait_sys("loss_first_lock", 60);
        step(); step();
        pll_lock = 1'b0;
        step(); step();
        n_checks++;
        if (sys_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_early: sys_rst_n=%b after 2 edges required 1", sys_rst_n);
        end
        step();
        n_checks++;
        if ({sys_rst_n, pll_reset, loss_cnt} !== {2'b01, exp_loss(1)}) begin
            n_fail++;
            $display("FAIL loss_response: got %b/%b/%0d required 0/1/%0d",
                     sys_rst_n, pll_reset, loss_cnt, exp_loss(1));
        end
        pll_lock = 1'b1;
        wait_sys("loss_relock", 60);
    endtask

    task automatic test_simultaneous();
        pll_lock = 1'b0;
        do_reset();
        repeat (5) step();
        pll_lock = 1'b1;
        repeat (8) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        n_checks++;
        if (pll_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_stable_held: pll_reset=%b at edge 15 required 0", pll_reset);
        end
        step();
        n_checks++;
        if ({locked, pll_reset, retry_cnt} !== 6'b01_0001) begin
            n_fail++;
            $display("FAIL simul_drop_wins: locked=%b pll_reset=%b retry=%0d required 0/1/1",
                     locked, pll_reset, retry_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        pll_lock = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wait_sys("midrst_run", 60);
            pll_lock = 1'b0;
            repeat (3) step();
            if (i < 4) pll_lock = 1'b1;
        end
        n = 0;
        while (!(retry_cnt === 4'd2 && pll_reset === 1'b0) && n < 150) begin step(); n++; end
        n_checks++;
        if ({retry_cnt, pll_reset, loss_cnt} !== {4'd2, 1'b0, exp_loss(5)}) begin
            n_fail++;
            $display("FAIL midrst_setup: retry=%0d pll_reset=%b loss=%0d required 2/0/%0d",
                     retry_cnt, pll_reset, loss_cnt, exp_loss(5));
        end
        step();
        do_reset();
        n_checks++;
        if (obs !== 16'h8000) begin
            n_fail++;
            $display("FAIL midrst_values: got %h required %h", obs, 16'h8000);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++;
            if (pll_reset !== (k < 4)) begin
                n_fail++;
                $display("FAIL midrst_pulse_edge%0d: pll_reset=%b required %b", k, pll_reset, k < 4);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        pll_lock = 1'b0;
        do_reset();
        hold = 0;
        for (int k = 0; k < 1500; k++) begin
            if (hold == 0) begin
                pll_lock = ~pll_lock;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
            end
            hold--;
            reset_n = ($urandom_range(0, 299) != 0);
            step();
            n_checks++;
            if (obs !== model_out()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h required %h", k, obs, model_out());
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_chatter();
        test_no_lock();
        test_loss_in_run();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the HDMI rPLL out of reset and qualifies its `lock` output. Runs on the 27 MHz crystal clock that also feeds the PLL. Drives the PLL `reset` input and debounces `lock`, then releases a synchronous active-low system reset to the TMDS/pixel logic. If lock is lost, it re-runs the PLL reset sequence; after a bounded number of failed attempts it enters a sticky fail state.

## Interface
Parameters:
- `RESET_CYCLES`, 32: width of each PLL reset pulse, in clkin cycles (≥1).
- `LOCK_TIMEOUT`, 27000: cycles to wait for lock after a reset pulse (1 ms at 27 MHz).
- `STABLE_CYCLES`, 2700: consecutive synchronized-lock cycles required before release (100 µs).
- `MAX_RETRIES`, 7: failed attempts tolerated before FAIL (≤15).

Ports:
- `clkin` in 1: 27 MHz crystal clock; the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `pll_lock` in 1: rPLL lock; asynchronous to clkin.
- `pll_reset` out 1: to the rPLL `reset` input; active high.
- `sys_rst_n` out 1: downstream reset; active low, synchronous to clkin.
- `locked` out 1: qualified lock; high only in RUN.
- `fail` out 1: sticky failure flag.
- `retry_cnt` out 4: failed attempts in the current acquisition.
- `loss_cnt` out 8: lock-loss events seen in RUN (see Configuration).

## Operation
- `pll_lock` passes through a 2-flop synchronizer to form `lock_s`. Only `lock_s` is used.
- A single cycle counter `cnt` is shared by all states. It is cleared on every state change. Its width is wide enough for max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- States and transitions:
  - ASSERT_RST: `pll_reset`=1. When `cnt`==RESET_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_reset`=0. If `lock_s`, go to STABLE. Otherwise, when `cnt`==LOCK_TIMEOUT-1, take the retry path.
  - STABLE: if `lock_s`==0, take the retry path. When `cnt`==STABLE_CYCLES-1 with `lock_s`=1, go to RUN.
  - RUN: `sys_rst_n`=1 and `locked`=1. On `lock_s`==0, go to ASSERT_RST. This clears `retry_cnt` and increments `loss_cnt`.
  - FAIL: `pll_reset`=1, `sys_rst_n`=0, `fail`=1. Only `reset_n` exits this state.
- Retry path:
  - If `retry_cnt`==MAX_RETRIES, go to FAIL.
  - Otherwise increment `retry_cnt` and go to ASSERT_RST.
- `retry_cnt` is cleared on entry to RUN. `loss_cnt` saturates at 255.
- `sys_rst_n` is 0 in every state except RUN.

## Timing
- Reset values (`reset_n`=0 at an edge): state ASSERT_RST, `cnt`=0, `pll_reset`=1, `sys_rst_n`=0, `locked`=0, `fail`=0, `retry_cnt`=0, `loss_cnt`=0, synchronizer flops=0.
- All outputs are registered. Each output changes on the same edge as the state register.
- `pll_reset` is high for exactly RESET_CYCLES cycles per pulse, starting from the first edge where `reset_n`=1.
- Latency from a `pll_lock` rise to STABLE is 3 edges: 2 synchronizer edges plus 1 state edge.
- Minimum latency from a `pll_lock` rise to `sys_rst_n`=1 is 3+STABLE_CYCLES edges.
- Latency from a `pll_lock` fall in RUN to `sys_rst_n`=0 and `pll_reset`=1 is 3 edges.
- If a lock drop and a counter terminal count occur in the same cycle, the lock drop wins. In STABLE this means retry, not RUN.
- `reset_n` low mid-sequence aborts immediately to the reset values. This includes the FAIL state.

## Configuration
- Macro: `PLL_SUP_LOSS_CNT_EN`.
- Defined: `loss_cnt` is implemented as described above.
- Undefined: no counter register is built. The `loss_cnt` port remains and is tied to 0.

## Structure
- Package `pll_sup_pkg` holds:
  - the state enum (ASSERT_RST, WAIT_LOCK, STABLE, RUN, FAIL);
  - default parameter constants;
  - the counter-width function.
- Sub-module `sync_2ff`: generic 1-bit two-flop synchronizer with a synchronous active-low reset to 0.

## Test plan
All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean lock: `pll_lock` rises 5 cycles after reset release.
  - `pll_reset` is high for exactly cycles 0–3.
  - `sys_rst_n` rises 11 edges after the `pll_lock` rise. `locked`=1, `retry_cnt`=0.
- Chatter: `pll_lock` drops for 1 cycle, 4 cycles into STABLE.
  - One retry occurs and `retry_cnt`=1.
  - A new 4-cycle `pll_reset` pulse is issued. `sys_rst_n` stays 0.
- No lock: `pll_lock` held at 0.
  - Three pulses are issued, with `retry_cnt` counting 0→1→2.
  - After the third timeout: `fail`=1, `pll_reset`=1 permanently, `sys_rst_n`=0.
- Loss in RUN: `pll_lock` falls.
  - 3 edges later: `sys_rst_n`=0, `pll_reset`=1, `loss_cnt`=1 (macro defined) or 0 (undefined).
  - Relock then restores `sys_rst_n`=1.
- Simultaneous event: `lock_s` falls on the same cycle `cnt`==7 in STABLE.
  - Required response is retry; RUN is never entered.
- Mid-sequence reset: `reset_n`=0 for 1 cycle during WAIT_LOCK, with `retry_cnt`=2 and `loss_cnt`=5.
  - Next edge: all outputs return to their reset values.
  - A fresh 4-cycle pulse follows.
